// File: rtl/sim_run_ctrl_if.sv
// Run-controller bundle between sim_run_ctrl and the harness around the CPU.
//   halt_in     : per-channel program-end request (level)
//   pause_in    : freeze the CPU while running
//   restart_in  : synchronous rerun from the reset sequence
//   cpu_rst_out : reset to the CPU core
//   cpu_rdy_out : ready/enable to the CPU core
//   run_cycles  : enabled cycles in the current run
//   done        : sticky, run ended by a halt
//   timeout     : sticky, run ended by the watchdog
//   halt_id     : lowest-index halt channel that ended the run
// master = harness side, slave = controller side.
interface sim_run_ctrl_if #(
  parameter int NUM_HALT  = 1,
  parameter int CNT_WIDTH = 32,
  parameter int HID_W     = (NUM_HALT > 1) ? $clog2(NUM_HALT) : 1
);
  logic [NUM_HALT-1:0]  halt_in;
  logic                 pause_in;
  logic                 restart_in;
  logic                 cpu_rst_out;
  logic                 cpu_rdy_out;
  logic [CNT_WIDTH-1:0] run_cycles;
  logic                 done;
  logic                 timeout;
  logic [HID_W-1:0]     halt_id;

  modport master (
    output halt_in, pause_in, restart_in,
    input  cpu_rst_out, cpu_rdy_out, run_cycles, done, timeout, halt_id
  );

  modport slave (
    input  halt_in, pause_in, restart_in,
    output cpu_rst_out, cpu_rdy_out, run_cycles, done, timeout, halt_id
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller for the RISC-V CPU top levels: stretches the CPU reset,
// gates CPU ready, counts enabled cycles, ends the run on a halt channel or
// on the cycle watchdog, and records why the run ended.
//   clk_in : system clock, rising edge
//   rst_in : asynchronous active-high reset
//   bus    : sim_run_ctrl_if.slave (halt/pause/restart in, status out)
//
// state   | meaning
// RST_SEQ | CPU held in reset, rst_cnt stretching
// RUN     | CPU enabled unless paused, counting cycles
// DONE    | terminal, ended by a halt channel
// TMO     | terminal, ended by the watchdog
module sim_run_ctrl #(
  parameter int RST_CYCLES     = 25,
  parameter int TIMEOUT_CYCLES = 1500,
  parameter int CNT_WIDTH      = 32,
  parameter int NUM_HALT       = 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  sim_run_ctrl_if.slave bus
);
  localparam int HID_W = (NUM_HALT > 1) ? $clog2(NUM_HALT) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]      RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RST_SEQ, RUN, DONE, TMO} state_t;

  state_t               state_q, state_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0] run_cycles_q, run_cycles_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [HID_W-1:0]     halt_id_q, halt_id_d;

  logic             run_en;
  logic             halt_any;
  logic [HID_W-1:0] halt_low;
  logic             wdog_fire;

  assign run_en   = (state_q == RUN) && !bus.pause_in;
  assign halt_any = |bus.halt_in;

  // Walk from the top down so the lowest set channel is the one kept.
  always_comb begin
    halt_low = '0;
    for (int i = NUM_HALT - 1; i >= 0; i--) begin
      if (bus.halt_in[i]) halt_low = HID_W'(i);
    end
  end

  assign wdog_fire = (TIMEOUT_CYCLES != 0) && run_en && (run_cycles_q == TMO_LAST);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= RST_SEQ;
      rst_cnt_q    <= '0;
      run_cycles_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      halt_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      halt_id_q    <= halt_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.restart_in) begin
      state_d = RST_SEQ;
    end else begin
      case (state_q)
        RST_SEQ: if (rst_cnt_q == RST_LAST) state_d = RUN;
        RUN: begin
          if (halt_any)       state_d = DONE;
          else if (wdog_fire) state_d = TMO;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rst_cnt_d    = rst_cnt_q;
    run_cycles_d = run_cycles_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    halt_id_d    = halt_id_q;
    if (bus.restart_in) begin
      rst_cnt_d    = '0;
      run_cycles_d = '0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      halt_id_d    = '0;
    end else begin
      case (state_q)
        RST_SEQ: rst_cnt_d = (rst_cnt_q == RST_LAST) ? '0 : rst_cnt_q + 1'b1;
        RUN: begin
          // Saturate so an unwatched run never wraps back to zero.
          if (run_en && (run_cycles_q != '1)) run_cycles_d = run_cycles_q + 1'b1;
          if (halt_any) begin
            done_d    = 1'b1;
            halt_id_d = halt_low;
          end else if (wdog_fire) begin
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cpu_rst_out = (state_q == RST_SEQ);
    bus.cpu_rdy_out = run_en;
    bus.run_cycles  = run_cycles_q;
    bus.done        = done_q;
    bus.timeout     = timeout_q;
    bus.halt_id     = halt_id_q;
  end
endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl. Instance a: RST_CYCLES=25,
// TIMEOUT_CYCLES=150, NUM_HALT=4. Instance b: RST_CYCLES=1, watchdog off,
// 4-bit counter, one halt channel (saturation corner).
module tb_sim_run_ctrl;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;

  always #5 clk_in = ~clk_in;

  sim_run_ctrl_if #(.NUM_HALT(4), .CNT_WIDTH(32)) bus_a ();
  sim_run_ctrl_if #(.NUM_HALT(1), .CNT_WIDTH(4))  bus_b ();

  sim_run_ctrl #(.RST_CYCLES(25), .TIMEOUT_CYCLES(150), .CNT_WIDTH(32), .NUM_HALT(4)) u_dut_a (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_a.slave)
  );

  sim_run_ctrl #(.RST_CYCLES(1), .TIMEOUT_CYCLES(0), .CNT_WIDTH(4), .NUM_HALT(1)) u_dut_b (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic restart_pulse();
    bus_a.restart_in = 1'b1;
    tick();
    bus_a.restart_in = 1'b0;
  endtask

  // Called with a in RST_SEQ, rst_cnt=0; halt_a held for the first halt_edges edges.
  task automatic rst_seq_chk(input string tag, input int halt_edges);
    int hi;
    hi = 0;
    for (int k = 1; k <= 24; k++) begin
      bus_a.halt_in = (k <= halt_edges) ? 4'b0001 : 4'b0000;
      tick();
      hi += int'(bus_a.cpu_rst_out);
    end
    chk({tag, "_rst_high_edges"}, 64'(hi), 64'd24);
    tick();
    chk({tag, "_rst_low"}, 64'(bus_a.cpu_rst_out), 64'd0);
    chk({tag, "_rdy"}, 64'(bus_a.cpu_rdy_out), 64'd1);
    chk({tag, "_run0"}, 64'(bus_a.run_cycles), 64'd0);
  endtask

  task automatic wait_run(input int target, input int budget);
    int b;
    b = 0;
    while (bus_a.run_cycles != 32'(target) && b < budget) begin
      tick();
      b++;
    end
    chk("wait_run", 64'(bus_a.run_cycles), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus_a.halt_in = '0; bus_a.pause_in = 1'b0; bus_a.restart_in = 1'b0;
    bus_b.halt_in = '0; bus_b.pause_in = 1'b0; bus_b.restart_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
    chk("rst_cpu_rst", 64'(bus_a.cpu_rst_out), 64'd1);
    chk("rst_cpu_rdy", 64'(bus_a.cpu_rdy_out), 64'd0);
    chk("rst_run", 64'(bus_a.run_cycles), 64'd0);
    chk("rst_done", 64'(bus_a.done), 64'd0);
    chk("rst_tmo", 64'(bus_a.timeout), 64'd0);
    chk("rst_hid", 64'(bus_a.halt_id), 64'd0);
    chk("b_rst_cpu_rst", 64'(bus_b.cpu_rst_out), 64'd1);

    // Power-on, with a halt held during the stretch that must be ignored.
    rst_in = 1'b0;
    rst_seq_chk("pon", 6);
    chk("pon_done", 64'(bus_a.done), 64'd0);
    tick(); chk("count1", 64'(bus_a.run_cycles), 64'd1);
    tick(); chk("count2", 64'(bus_a.run_cycles), 64'd2);
    tick(); chk("count3", 64'(bus_a.run_cycles), 64'd3);

    // Pause freezes the count.
    bus_a.pause_in = 1'b1;
    #1;
    chk("pause_rdy", 64'(bus_a.cpu_rdy_out), 64'd0);
    repeat (10) tick();
    chk("pause_run", 64'(bus_a.run_cycles), 64'd3);
    chk("pause_rdy_end", 64'(bus_a.cpu_rdy_out), 64'd0);
    bus_a.pause_in = 1'b0;
    tick();
    chk("unpause_run", 64'(bus_a.run_cycles), 64'd4);

    // Instance b has run long enough to saturate at 15.
    chk("b_sat_run", 64'(bus_b.run_cycles), 64'd15);
    chk("b_sat_tmo", 64'(bus_b.timeout), 64'd0);
    chk("b_sat_rdy", 64'(bus_b.cpu_rdy_out), 64'd1);

    // Halt at run_cycles=100 on channels 2 and 3.
    wait_run(100, 200);
    bus_a.halt_in = 4'b1100;
    tick();
    chk("halt_done", 64'(bus_a.done), 64'd1);
    chk("halt_hid", 64'(bus_a.halt_id), 64'd2);
    chk("halt_run", 64'(bus_a.run_cycles), 64'd101);
    chk("halt_rdy", 64'(bus_a.cpu_rdy_out), 64'd0);
    chk("halt_rst", 64'(bus_a.cpu_rst_out), 64'd0);
    chk("halt_tmo", 64'(bus_a.timeout), 64'd0);
    bus_a.halt_in = 4'b0001;
    repeat (3) tick();
    chk("halt_frz_hid", 64'(bus_a.halt_id), 64'd2);
    chk("halt_frz_run", 64'(bus_a.run_cycles), 64'd101);
    bus_a.halt_in = 4'b0000;

    restart_pulse();
    chk("rs1_rst", 64'(bus_a.cpu_rst_out), 64'd1);
    chk("rs1_run", 64'(bus_a.run_cycles), 64'd0);
    chk("rs1_done", 64'(bus_a.done), 64'd0);
    chk("rs1_hid", 64'(bus_a.halt_id), 64'd0);
    rst_seq_chk("rs1", 0);

    // Watchdog fires at 150.
    wait_run(150, 300);
    chk("wd_tmo", 64'(bus_a.timeout), 64'd1);
    chk("wd_done", 64'(bus_a.done), 64'd0);
    chk("wd_rdy", 64'(bus_a.cpu_rdy_out), 64'd0);
    bus_a.halt_in = 4'b0010;
    repeat (2) tick();
    chk("wd_halt_tmo", 64'(bus_a.timeout), 64'd1);
    chk("wd_halt_done", 64'(bus_a.done), 64'd0);
    chk("wd_halt_hid", 64'(bus_a.halt_id), 64'd0);
    chk("wd_halt_run", 64'(bus_a.run_cycles), 64'd150);
    bus_a.halt_in = 4'b0000;

    // Halt while paused.
    restart_pulse();
    rst_seq_chk("rs2", 0);
    repeat (5) tick();
    chk("ph_pre_run", 64'(bus_a.run_cycles), 64'd5);
    bus_a.pause_in = 1'b1;
    bus_a.halt_in  = 4'b0100;
    tick();
    chk("ph_done", 64'(bus_a.done), 64'd1);
    chk("ph_hid", 64'(bus_a.halt_id), 64'd2);
    chk("ph_run", 64'(bus_a.run_cycles), 64'd5);
    bus_a.pause_in = 1'b0;
    bus_a.halt_in  = 4'b0000;

    // Halt on the watchdog edge: halt wins, count still increments.
    restart_pulse();
    rst_seq_chk("rs3", 0);
    wait_run(149, 300);
    bus_a.halt_in = 4'b1000;
    tick();
    chk("col_done", 64'(bus_a.done), 64'd1);
    chk("col_tmo", 64'(bus_a.timeout), 64'd0);
    chk("col_run", 64'(bus_a.run_cycles), 64'd150);
    chk("col_hid", 64'(bus_a.halt_id), 64'd3);
    bus_a.halt_in = 4'b0000;

    // Restart mid-stretch starts the stretch over.
    restart_pulse();
    repeat (10) tick();
    chk("mid_rst", 64'(bus_a.cpu_rst_out), 64'd1);
    restart_pulse();
    rst_seq_chk("rs4", 0);

    // Restart overrides a simultaneous halt in RUN.
    repeat (3) tick();
    chk("ovr_pre_run", 64'(bus_a.run_cycles), 64'd3);
    bus_a.restart_in = 1'b1;
    bus_a.halt_in    = 4'b0001;
    tick();
    bus_a.restart_in = 1'b0;
    bus_a.halt_in    = 4'b0000;
    chk("ovr_done", 64'(bus_a.done), 64'd0);
    chk("ovr_rst", 64'(bus_a.cpu_rst_out), 64'd1);
    chk("ovr_run", 64'(bus_a.run_cycles), 64'd0);
    rst_seq_chk("rs5", 0);
    repeat (4) tick();
    chk("ar_pre_run", 64'(bus_a.run_cycles), 64'd4);

    // Single-channel halt on instance b.
    bus_b.halt_in = 1'b1;
    tick();
    bus_b.halt_in = 1'b0;
    chk("b_halt_done", 64'(bus_b.done), 64'd1);
    chk("b_halt_hid", 64'(bus_b.halt_id), 64'd0);
    chk("b_halt_run", 64'(bus_b.run_cycles), 64'd15);

    // Asynchronous reset between edges.
    #3;
    rst_in = 1'b1;
    #1;
    chk("ar_rst", 64'(bus_a.cpu_rst_out), 64'd1);
    chk("ar_run", 64'(bus_a.run_cycles), 64'd0);
    chk("ar_rdy", 64'(bus_a.cpu_rdy_out), 64'd0);
    chk("ar_b_done", 64'(bus_b.done), 64'd0);
    rst_in = 1'b0;
    rst_seq_chk("ar", 0);
    tick();
    chk("ar_count1", 64'(bus_a.run_cycles), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
